feedback_scorer: RTL and testbench

- Reader-side consumer of the guess history block. Scores a committed guess (four 3-bit pegs) against the stored secret code.
- Multi-cycle FSM computes exact (right colour, right slot) and partial (right colour, wrong slot) counts. Duplicate colours are handled correctly.
- Produces win and game_over status, which the top level uses to end the game and drive the display.

---
 rtl/scoring_pkg.sv | 27 ++
 rtl/feedback_scorer_if.sv | 32 +++
 rtl/first_match_finder.sv | 24 ++
 rtl/feedback_scorer.sv | 117 +++++++++++
 tb/tb_feedback_scorer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scoring_pkg.sv
// Shared types and sizes for scoring a guess against the secret code.
// Codes are packed arrays so element k corresponds to peg k (secret_k / guess_k).
package scoring_pkg;

  localparam int PEGS    = 4;
  localparam int COLOR_W = 3;
  localparam int CNT_W   = 3;
  localparam int IDX_W   = $clog2(PEGS);

  typedef logic [COLOR_W-1:0] peg_t;
  typedef peg_t [PEGS-1:0]    code_t;

  typedef enum logic [1:0] {
    IDLE,
    EXACT,
    PARTIAL,
    REPORT
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [PEGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < PEGS; k++) c = c + CNT_W'(v[k]);
    return c;
  endfunction

endpackage

// File: rtl/feedback_scorer_if.sv
// Bus between the game controller (master) and the feedback scorer (slave).
// Strobes secret_load and score_start are single-cycle pulses sampled on the rising edge.
// There is no backpressure: a pulse is accepted only while busy is low and is otherwise
// dropped, never queued. done is a one-cycle pulse marking the cycle exact/partial update.
interface feedback_scorer_if;
  import scoring_pkg::*;

  peg_t             secret3, secret2, secret1, secret0;
  logic             secret_load;
  peg_t             guess3, guess2, guess1, guess0;
  logic             score_start;
  logic             last_turn;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] exact;
  logic [CNT_W-1:0] partial;
  logic             win;
  logic             game_over;

  modport master (
    output secret3, secret2, secret1, secret0, secret_load,
    output guess3, guess2, guess1, guess0, score_start, last_turn,
    input  busy, done, exact, partial, win, game_over
  );

  modport slave (
    input  secret3, secret2, secret1, secret0, secret_load,
    input  guess3, guess2, guess1, guess0, score_start, last_turn,
    output busy, done, exact, partial, win, game_over
  );

endinterface

// File: rtl/first_match_finder.sv
// Finds the lowest secret slot of a given colour that has not already been claimed.
module first_match_finder
  import scoring_pkg::*;
(
  input  peg_t             colour,
  input  code_t            secret,
  input  logic [PEGS-1:0]  used,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = PEGS - 1; j >= 0; j--) begin
      if (!used[j] && secret[j] == colour) begin
        found = 1'b1;
        idx   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/feedback_scorer.sv
// Scores a snapshotted guess against the latched secret: one EXACT cycle, one PARTIAL
// cycle per guess peg, then REPORT updates the counts and the sticky win/game_over flags.
module feedback_scorer
  import scoring_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  feedback_scorer_if.slave   bus,
  output state_t             dbg_state
);

  state_t           state;
  code_t            secret_q;
  code_t            guess_q;
  logic             last_q;
  logic [PEGS-1:0]  match_g;
  logic [PEGS-1:0]  match_s;
  logic [CNT_W-1:0] exact_acc;
  logic [CNT_W-1:0] partial_acc;
  logic [IDX_W-1:0] idx;

  code_t            secret_in;
  code_t            guess_in;
  logic [PEGS-1:0]  eq;
  logic             fm_found;
  logic [IDX_W-1:0] fm_idx;

  assign secret_in = {bus.secret3, bus.secret2, bus.secret1, bus.secret0};
  assign guess_in  = {bus.guess3, bus.guess2, bus.guess1, bus.guess0};
  assign dbg_state = state;

  always_comb begin
    eq = '0;
    for (int k = 0; k < PEGS; k++) eq[k] = (guess_q[k] == secret_q[k]);
  end

  first_match_finder u_finder (
    .colour (guess_q[idx]),
    .secret (secret_q),
    .used   (match_s),
    .found  (fm_found),
    .idx    (fm_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      secret_q      <= '0;
      guess_q       <= '0;
      last_q        <= 1'b0;
      match_g       <= '0;
      match_s       <= '0;
      exact_acc     <= '0;
      partial_acc   <= '0;
      idx           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.exact     <= '0;
      bus.partial   <= '0;
      bus.win       <= 1'b0;
      bus.game_over <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.secret_load) begin
            secret_q      <= secret_in;
            bus.exact     <= '0;
            bus.partial   <= '0;
            bus.win       <= 1'b0;
            bus.game_over <= 1'b0;
          end else if (bus.score_start && !bus.game_over) begin
            guess_q     <= guess_in;
            last_q      <= bus.last_turn;
            match_g     <= '0;
            match_s     <= '0;
            exact_acc   <= '0;
            partial_acc <= '0;
            idx         <= '0;
            bus.busy    <= 1'b1;
            state       <= EXACT;
          end
        end
        EXACT: begin
          match_g   <= eq;
          match_s   <= eq;
          exact_acc <= popcount(eq);
          idx       <= '0;
          state     <= PARTIAL;
        end
        PARTIAL: begin
          // Exact hits already own their secret slot via match_s, so they cannot be reclaimed.
          if (!match_g[idx] && fm_found) begin
            match_s[fm_idx] <= 1'b1;
            partial_acc     <= partial_acc + CNT_W'(1);
          end
          if (idx == IDX_W'(PEGS - 1)) begin
            state <= REPORT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        REPORT: begin
          bus.exact     <= exact_acc;
          bus.partial   <= partial_acc;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          bus.win       <= (exact_acc == CNT_W'(PEGS));
          bus.game_over <= (exact_acc == CNT_W'(PEGS)) || last_q;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feedback_scorer.sv
// Scoreboard bench for feedback_scorer: an independent colour-histogram model queues the
// expected result per accepted score request; the done monitor pops and compares.
module tb_feedback_scorer;
  import scoring_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  state_t dbg_state;
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;

  logic [7:0] exp_q[$];     // {exact[2:0], partial[2:0], win, game_over}
  int         start_q[$];
  logic [2:0] m_sec[4];
  logic       m_win, m_go;
  bit         allow_done = 1'b1;

  feedback_scorer_if bus ();

  feedback_scorer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Colour-histogram scoring: total common colours minus exact hits gives partials.
  function automatic logic [5:0] model(input logic [2:0] g[4]);
    int ex, tot, cs, cg;
    ex  = 0;
    tot = 0;
    for (int k = 0; k < 4; k++) if (g[k] == m_sec[k]) ex++;
    for (int c = 0; c < 8; c++) begin
      cs = 0;
      cg = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_sec[k] == c[2:0]) cs++;
        if (g[k] == c[2:0]) cg++;
      end
      tot += (cs < cg) ? cs : cg;
    end
    return {ex[2:0], 3'(tot - ex)};
  endfunction

  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [7:0] e;
        int s;
        e = exp_q.pop_front();
        s = start_q.pop_front();
        check("exact", bus.exact, e[7:5]);
        check("partial", bus.partial, e[4:2]);
        check("win", bus.win, e[1]);
        check("game_over", bus.game_over, e[0]);
        check("latency", cyc - s, 6);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_win = 1'b0;
    m_go  = 1'b0;
    for (int k = 0; k < 4; k++) m_sec[k] = 3'd0;
  endtask

  task automatic load_secret(input logic [2:0] s3, s2, s1, s0);
    @(negedge clk);
    {bus.secret3, bus.secret2, bus.secret1, bus.secret0} = {s3, s2, s1, s0};
    bus.secret_load = 1'b1;
    @(negedge clk);
    bus.secret_load = 1'b0;
    m_sec[3] = s3; m_sec[2] = s2; m_sec[1] = s1; m_sec[0] = s0;
    m_win = 1'b0;
    m_go  = 1'b0;
  endtask

  // Drives one score request; queues an expectation only if the model accepts it.
  task automatic score(input logic [2:0] g3, g2, g1, g0, input logic lt);
    logic [2:0] g[4];
    logic [5:0] r;
    @(negedge clk);
    {bus.guess3, bus.guess2, bus.guess1, bus.guess0} = {g3, g2, g1, g0};
    bus.last_turn   = lt;
    bus.score_start = 1'b1;
    @(negedge clk);
    bus.score_start = 1'b0;
    if (!m_go) begin
      g[3] = g3; g[2] = g2; g[1] = g1; g[0] = g0;
      r = model(g);
      m_win = (r[5:3] == 3'd4);
      m_go  = m_win || lt;
      exp_q.push_back({r, m_win, m_go});
      start_q.push_back(cyc);
    end
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      start_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    {bus.secret3, bus.secret2, bus.secret1, bus.secret0} = '0;
    {bus.guess3, bus.guess2, bus.guess1, bus.guess0} = '0;
    bus.secret_load = 1'b0;
    bus.score_start = 1'b0;
    bus.last_turn   = 1'b0;
    do_reset();

    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_exact", bus.exact, 0);
    check("rst_partial", bus.partial, 0);
    check("rst_win", bus.win, 0);
    check("rst_game_over", bus.game_over, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Full match, then reload and all-partials.
    load_secret(3'd1, 3'd2, 3'd3, 3'd4);
    score(3'd1, 3'd2, 3'd3, 3'd4, 1'b0);
    @(negedge clk);
    check("busy_high", bus.busy, 1);
    wait_quiet();
    load_secret(3'd1, 3'd2, 3'd3, 3'd4);
    check("load_clear_win", bus.win, 0);
    score(3'd4, 3'd3, 3'd2, 3'd1, 1'b0);
    wait_quiet();
    check("hold_partial", bus.partial, 4);

    // Duplicate colours.
    load_secret(3'd1, 3'd1, 3'd2, 3'd2);
    score(3'd1, 3'd2, 3'd1, 3'd1, 1'b0);
    wait_quiet();
    load_secret(3'd5, 3'd5, 3'd5, 3'd5);
    score(3'd5, 3'd0, 3'd0, 3'd0, 1'b0);
    wait_quiet();

    // Busy rejection: guess changes at N+1, a second start at N+2 and a secret_load are dropped.
    load_secret(3'd1, 3'd2, 3'd3, 3'd4);
    score(3'd4, 3'd2, 3'd1, 3'd3, 1'b0);
    {bus.guess3, bus.guess2, bus.guess1, bus.guess0} = {3'd1, 3'd2, 3'd3, 3'd4};
    bus.score_start = 1'b1;
    @(negedge clk);
    bus.score_start = 1'b0;
    bus.secret_load = 1'b1;
    {bus.secret3, bus.secret2, bus.secret1, bus.secret0} = {3'd7, 3'd7, 3'd7, 3'd7};
    @(negedge clk);
    bus.secret_load = 1'b0;
    wait_quiet();
    repeat (8) @(negedge clk);
    check("busy_idle_after", bus.busy, 0);

    // secret_load wins over score_start in the same cycle.
    @(negedge clk);
    {bus.secret3, bus.secret2, bus.secret1, bus.secret0} = {3'd6, 3'd6, 3'd0, 3'd0};
    bus.secret_load = 1'b1;
    bus.score_start = 1'b1;
    @(negedge clk);
    bus.secret_load = 1'b0;
    bus.score_start = 1'b0;
    m_sec[3] = 3'd6; m_sec[2] = 3'd6; m_sec[1] = 3'd0; m_sec[0] = 3'd0;
    check("prio_busy", bus.busy, 0);
    check("prio_exact_clear", bus.exact, 0);
    score(3'd0, 3'd6, 3'd0, 3'd6, 1'b0);
    wait_quiet();

    // Final turn: game over without a win, later starts ignored, reload clears.
    load_secret(3'd1, 3'd2, 3'd3, 3'd4);
    score(3'd1, 3'd2, 3'd0, 3'd0, 1'b1);
    wait_quiet();
    score(3'd1, 3'd2, 3'd3, 3'd4, 1'b0);
    check("go_ignore_busy", bus.busy, 0);
    repeat (8) @(negedge clk);
    check("go_hold_exact", bus.exact, 2);
    load_secret(3'd0, 3'd0, 3'd0, 3'd0);
    check("reload_go", bus.game_over, 0);
    check("reload_win", bus.win, 0);
    check("reload_exact", bus.exact, 0);
    check("reload_partial", bus.partial, 0);

    // Reset at edge N+3 aborts scoring.
    load_secret(3'd3, 3'd3, 3'd1, 3'd2);
    score(3'd3, 3'd3, 3'd1, 3'd2, 1'b0);
    exp_q.delete();
    start_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    m_win = 1'b0;
    m_go  = 1'b0;
    for (int k = 0; k < 4; k++) m_sec[k] = 3'd0;
    repeat (8) @(negedge clk);
    check("abort_exact", bus.exact, 0);
    check("abort_win", bus.win, 0);
    // Secret was cleared by reset, so an all-zero guess wins.
    score(3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    wait_quiet();

    // Random games.
    for (int t = 0; t < 20; t++) begin
      load_secret(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      score(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      wait_quiet();
      check("rand_sum_le_pegs", (32'(bus.exact) + 32'(bus.partial)) <= 4, 1);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
